// File: rtl/div_iter_64_32_2sc.sv
// Iterative signed 64/32 divider: restoring radix-2 on magnitudes, one quotient bit per clock.
// Inverse companion of the 32x32 signed multiplier; start/busy/done handshake.
module div_iter_64_32_2sc (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, PREP, CALC, SIGN} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_a;
    logic [31:0] r_b;
    logic        r_sa;
    logic        r_sb;
    logic [63:0] r_amag;
    logic [31:0] r_bmag;
    logic [31:0] r_pr;
    logic [63:0] r_qm;
    logic [5:0]  r_cnt;

    logic [63:0] w_amag;
    logic [31:0] w_bmag;
    logic [32:0] w_pr_shift;
    logic [32:0] w_pr_sub;
    logic        w_pr_ge;
    logic        w_neg;
    logic        w_q_legal;
    logic [31:0] w_q_signed;
    logic [31:0] w_r_signed;

    // Magnitudes: the negation of the most negative value wraps to 2^63 / 2^31 unsigned.
    assign w_amag     = r_sa ? (~r_a + 64'd1) : r_a;
    assign w_bmag     = r_sb ? (~r_b + 32'd1) : r_b;

    // The restored remainder is always < b_mag <= 2^31, so 32 bits hold it between steps.
    assign w_pr_shift = {r_pr, r_amag[r_cnt]};
    assign w_pr_ge    = (w_pr_shift >= {1'b0, r_bmag});
    assign w_pr_sub   = w_pr_shift - {1'b0, r_bmag};

    assign w_neg      = r_sa ^ r_sb;
    assign w_q_legal  = w_neg ? (r_qm <= 64'h0000_0000_8000_0000)
                              : (r_qm <= 64'h0000_0000_7FFF_FFFF);
    assign w_q_signed = w_neg ? (~r_qm[31:0] + 32'd1) : r_qm[31:0];
    assign w_r_signed = r_sa  ? (~r_pr + 32'd1) : r_pr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = PREP;
            PREP: w_state_next = (r_b == 32'd0) ? IDLE : CALC;
            CALC: if (r_cnt == 6'd0) w_state_next = SIGN;
            SIGN: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_amag      <= '0;
            r_bmag      <= '0;
            r_pr        <= '0;
            r_qm        <= '0;
            r_cnt       <= '0;
            q           <= '0;
            r           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_sa <= a[63];
                        r_sb <= b[31];
                        busy <= 1'b1;
                    end
                end
                PREP: begin
                    r_amag <= w_amag;
                    r_bmag <= w_bmag;
                    r_pr   <= '0;
                    r_qm   <= '0;
                    r_cnt  <= 6'd63;
                    if (r_b == 32'd0) begin
                        q           <= 32'hFFFF_FFFF;
                        r           <= r_a[31:0];
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                CALC: begin
                    r_pr  <= w_pr_ge ? w_pr_sub[31:0] : w_pr_shift[31:0];
                    r_qm  <= {r_qm[62:0], w_pr_ge};
                    r_cnt <= r_cnt - 6'd1;
                end
                SIGN: begin
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    if (w_q_legal) begin
                        q        <= w_q_signed;
                        r        <= w_r_signed;
                        overflow <= 1'b0;
                    end else begin
                        q        <= w_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        r        <= '0;
                        overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_64_32_2sc.sv
// Directed-vector bench for div_iter_64_32_2sc: signs, multiplier round trips, overflow,
// divide-by-zero, ignored start while busy and mid-operation reset.
module tb_div_iter_64_32_2sc;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int n_checks;
    int n_errors;

    div_iter_64_32_2sc dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .q           (q),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one division; lat = rising edges after the accepting edge until done is seen.
    // pulse_at > 0 drives a stray start (with other operands) that many cycles into the run.
    task automatic run_div(input string tag, input logic [63:0] av, input logic [31:0] bv,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input logic eov, input int elat, input int pulse_at);
        int n;
        int busy_cnt;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = ~bv;
        n = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (pulse_at > 0 && n == pulse_at) begin
                start = 1'b1;
                a = 64'd5;
                b = 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        $display("div %s a=%h b=%h -> q=%h r=%h dz=%0b ov=%0b lat=%0d",
                 tag, av, bv, q, r, div_by_zero, overflow, n);
        check({tag, "_lat"},  64'(n), 64'(elat));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(elat));
        check({tag, "_q"},    64'(q), 64'(eq));
        check({tag, "_r"},    64'(r), 64'(er));
        check({tag, "_dz"},   64'(div_by_zero), 64'(edz));
        check({tag, "_ov"},   64'(overflow), 64'(eov));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"},  {q, r}, {eq, er});
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] x;
        logic [31:0] y;
        logic signed [63:0] xs;
        logic signed [63:0] ys;
        logic signed [63:0] prod;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_q",    64'(q), 64'd0);
        check("rst_r",    64'(r), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_div("pp",     64'd100,                   32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 66, 0);
        run_div("np",     64'hFFFF_FFFF_FFFF_FF9C,   32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0, 66, 0);
        run_div("pn",     64'd100,                   32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 1'b0, 66, 0);
        run_div("nn",     64'hFFFF_FFFF_FFFF_FF9C,   32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0, 66, 0);
        run_div("exact",  64'hFFFF_FFFF_FFFF_FF9C,   32'd25,         32'hFFFF_FFFC,  32'd0,          1'b0, 1'b0, 66, 0);
        run_div("minmin", 64'h4000_0000_0000_0000,   32'h8000_0000,  32'h8000_0000,  32'd0,          1'b0, 1'b0, 66, 0);
        run_div("ovpos",  64'h4000_0000_0000_0000,   32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd0,          1'b0, 1'b1, 66, 0);
        run_div("ovm1",   64'h8000_0000_0000_0000,   32'hFFFF_FFFF,  32'h7FFF_FFFF,  32'd0,          1'b0, 1'b1, 66, 0);
        run_div("ovneg",  64'hC000_0000_0000_0000,   32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, 66, 0);
        run_div("edgeq",  64'h0000_0000_7FFF_FFFF,   32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 1'b0, 66, 0);
        run_div("dz",     64'h1234_5678_9ABC_DEF0,   32'd0,          32'hFFFF_FFFF,  32'h9ABC_DEF0,  1'b1, 1'b0, 1,  0);
        run_div("afterdz", 64'd100,                  32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 66, 0);

        // Stray start mid-run must not restart or queue a second division.
        run_div("ign",    64'd1000,                  32'hFFFF_FFFD,  32'hFFFF_FEB3,  32'd1,          1'b0, 1'b0, 66, 10);
        count_dones(80, cnt);
        check("ign_extra_done", 64'(cnt), 64'd0);

        // Reset in mid-operation: outputs clear at once, no done ever appears.
        @(negedge clk);
        a = 64'd1000;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        count_dones(29, cnt);
        check("rst_mid_early_done", 64'(cnt), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_qr",   {q, r}, 64'd0);
        check("rst_mid_ov",   64'(overflow), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        count_dones(80, cnt);
        check("rst_mid_no_done", 64'(cnt), 64'd0);
        run_div("postrst", 64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 66, 0);

        // Multiplier round trip: (x*y)/y == x with zero remainder.
        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            y = $urandom;
            if (y == 32'd0) y = 32'd1;
            xs = {{32{x[31]}}, x};
            ys = {{32{y[31]}}, y};
            prod = xs * ys;
            run_div("rt", prod, y, x, 32'd0, 1'b0, 1'b0, 66, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
